// File: rtl/galois_pow5_arbiter_if.sv
// Requester-side channels of the shared x^5 unit arbiter.
// Latency: none, wiring only.
// Backpressure: req_valid/req_ready on the operand channel, resp_valid/resp_ready on the result channel.
//
// Ports (as bundled signals):
//   req_valid  [NUM_REQ]         requester i has an operand pending
//   req_ready  [NUM_REQ]         one-hot, operand i accepted this cycle
//   req_base   [NUM_REQ*N_BITS]  operand i at [i*N_BITS +: N_BITS]
//   resp_valid [NUM_REQ]         one-hot, result for requester i is valid
//   resp_ready [NUM_REQ]         requester i consumes the result
//   resp_data  [N_BITS]          shared result bus, qualified by resp_valid
//   resp_err                     resp_data invalid, watchdog expired
interface galois_pow5_arbiter_if #(
  parameter int N_BITS  = 254,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*N_BITS-1:0] req_base;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [N_BITS-1:0]         resp_data;
  logic                      resp_err;

  // Requesters drive operands and consume results.
  modport master (
    output req_valid, req_base, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  // The arbiter accepts operands and returns results.
  modport slave (
    input  req_valid, req_base, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/galois_pow5_arbiter.sv
// Round-robin sharing of one multi-cycle galois_pow_5 unit between NUM_REQ requesters.
// Latency: accept to resp_valid = 2 + unit cycles to done (or 2 + TIMEOUT on watchdog expiry).
// Backpressure: one job in flight; result held until the granted requester's resp_ready, new requests only in IDLE.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   req_if (slave)    per-requester operand and result channels
//   grant_id          index of the current/last granted requester
//   busy              high in every state except IDLE
//   pow_rst, pow_en   registered control to the unit (rst active-high)
//   pow_base          registered operand to the unit
//   pow_result        result from the unit
//   pow_done          completion flag from the unit
module galois_pow5_arbiter #(
  parameter int N_BITS  = 254,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  galois_pow5_arbiter_if.slave       req_if,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       pow_rst,
  output logic                       pow_en,
  output logic [N_BITS-1:0]          pow_base,
  input  logic [N_BITS-1:0]          pow_result,
  input  logic                       pow_done
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [N_BITS-1:0]   base_q, base_d;
  logic [N_BITS-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic                pow_rst_q, pow_rst_d;
  logic                pow_en_q, pow_en_d;
  logic [15:0]         wd_q, wd_d;

  logic                pick_found;
  logic [GW-1:0]       pick_idx;

  // Round-robin search: first pending requester at or above ptr, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!pick_found && req_if.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  // Acceptance is combinational in IDLE; gating with rst keeps it quiet while reset is held.
  assign req_if.req_ready = (state_q == S_IDLE && rst && pick_found) ? (ONE_HOT0 << pick_idx) : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    base_d       = base_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = resp_valid_q;
    pow_rst_d    = pow_rst_q;
    pow_en_d     = pow_en_q;
    wd_d         = wd_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          base_d  = req_if.req_base[int'(pick_idx)*N_BITS +: N_BITS];
          grant_d = pick_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Unit has seen one reset cycle with the new base stable; release it.
        pow_rst_d = 1'b0;
        pow_en_d  = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + 16'd1;
        // done wins over a simultaneous watchdog expiry.
        if (pow_done) begin
          resp_data_d  = pow_result;
          resp_err_d   = 1'b0;
          resp_valid_d = ONE_HOT0 << grant_q;
          pow_rst_d    = 1'b1;
          pow_en_d     = 1'b0;
          state_d      = S_RESP;
        end else if (wd_d == WD_LIMIT) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = ONE_HOT0 << grant_q;
          pow_rst_d    = 1'b1;
          pow_en_d     = 1'b0;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (req_if.resp_ready[grant_q]) begin
          resp_valid_d = '0;
          ptr_d        = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          wd_d         = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      base_q       <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= '0;
      pow_rst_q    <= 1'b1;
      pow_en_q     <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      base_q       <= base_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      pow_rst_q    <= pow_rst_d;
      pow_en_q     <= pow_en_d;
      wd_q         <= wd_d;
    end
  end

  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_data  = resp_data_q;
  assign req_if.resp_err   = resp_err_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q != S_IDLE);
  assign pow_rst           = pow_rst_q;
  assign pow_en            = pow_en_q;
  assign pow_base          = base_q;

endmodule

// File: tb/tb_galois_pow5_arbiter.sv
// Directed bench for galois_pow5_arbiter with a behavioural x^5 unit stub.
// Latency: stub raises done after STUB_LAT enabled edges, or never when stub_hang is set.
// Backpressure: requesters and result consumers are driven from the directed sequence.
module tb_galois_pow5_arbiter;
  localparam int NB       = 32;
  localparam int NR       = 4;
  localparam int TO       = 16;
  localparam int STUB_LAT = 5;
  localparam int GW       = $clog2(NR);

  logic          clk;
  logic          rst;
  logic [GW-1:0] grant_id;
  logic          busy;
  logic          pow_rst;
  logic          pow_en;
  logic [NB-1:0] pow_base;
  logic [NB-1:0] pow_result;
  logic          pow_done;
  logic          stub_hang;
  logic [7:0]    stub_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int ens;

  galois_pow5_arbiter_if #(.N_BITS(NB), .NUM_REQ(NR)) rif ();

  galois_pow5_arbiter #(.N_BITS(NB), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (rif),
    .grant_id   (grant_id),
    .busy       (busy),
    .pow_rst    (pow_rst),
    .pow_en     (pow_en),
    .pow_base   (pow_base),
    .pow_result (pow_result),
    .pow_done   (pow_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operands used here are small, so plain x^5 equals x^5 mod p.
  function automatic logic [NB-1:0] p5(input logic [NB-1:0] b);
    return b * b * b * b * b;
  endfunction

  always_ff @(posedge clk) begin
    if (pow_rst) begin
      stub_cnt   <= '0;
      pow_done   <= 1'b0;
      pow_result <= '0;
    end else if (pow_en && !pow_done) begin
      stub_cnt <= stub_cnt + 8'd1;
      if (stub_cnt == 8'(STUB_LAT - 1) && !stub_hang) begin
        pow_done   <= 1'b1;
        pow_result <= p5(pow_base);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_req_ready"},  rif.req_ready,  0);
    chk({pfx, "_resp_valid"}, rif.resp_valid, 0);
    chk({pfx, "_resp_data"},  rif.resp_data,  0);
    chk({pfx, "_resp_err"},   rif.resp_err,   0);
    chk({pfx, "_grant_id"},   grant_id,       0);
    chk({pfx, "_busy"},       busy,           0);
    chk({pfx, "_pow_rst"},    pow_rst,        1);
    chk({pfx, "_pow_en"},     pow_en,         0);
    chk({pfx, "_pow_base"},   pow_base,       0);
  endtask

  task automatic set_base(input int g, input logic [NB-1:0] b);
    rif.req_base[g*NB +: NB] = b;
  endtask

  // Serve the next grant: expect requester g, then its result; optionally stall the result.
  task automatic serve_one(input int g, input logic [NB-1:0] exp_d, input logic exp_e,
                           input int hold, output int l, output int e);
    int  n;
    bit  bad;
    logic [NR-1:0] oh;
    oh = NR'(1) << g;
    n  = 0;
    while (rif.req_ready == 0 && n < 200) begin
      step();
      n++;
    end
    chk("grant_onehot", rif.req_ready, oh);
    l = 0;
    e = 0;
    step();
    l++;
    chk("ready_one_cycle", rif.req_ready, 0);
    rif.req_valid[g] = 1'b0;
    #1;
    chk("grant_id", grant_id, g);
    chk("busy_load", busy, 1);
    while (rif.resp_valid == 0 && l < 200) begin
      if (pow_en) e++;
      step();
      l++;
    end
    chk("resp_valid", rif.resp_valid, oh);
    chk("resp_data", rif.resp_data, exp_d);
    chk("resp_err", rif.resp_err, exp_e);
    bad = 1'b0;
    for (int k = 0; k < hold; k++) begin
      rif.resp_ready = ~oh;
      step();
      if (rif.resp_valid != oh || rif.resp_data != exp_d || !busy || rif.req_ready != 0)
        bad = 1'b1;
    end
    if (hold > 0) chk("bp_stable", bad, 0);
    rif.resp_ready = oh;
    step();
    rif.resp_ready = '0;
    #1;
    chk("resp_cleared", rif.resp_valid, 0);
  endtask

  initial begin
    rst           = 1'b0;
    stub_hang     = 1'b0;
    rif.req_valid  = '0;
    rif.req_base   = '0;
    rif.resp_ready = '0;
    step();
    step();
    check_reset_vals("rst");
    rst = 1'b1;
    step();

    // Single requester 0, base 2 -> 32; done after STUB_LAT+1 RUN cycles.
    set_base(0, 2);
    rif.req_valid[0] = 1'b1;
    #1;
    serve_one(0, 32, 0, 0, lat, ens);
    chk("t1_latency", lat, 3 + STUB_LAT);
    chk("t1_idle", busy, 0);

    // All four at once from ptr=0.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < NR; i++) set_base(i, NB'(i));
    rif.req_valid = 4'hF;
    #1;
    serve_one(0, 0, 0, 0, lat, ens);
    serve_one(1, 1, 0, 0, lat, ens);
    serve_one(2, 32, 0, 0, lat, ens);
    serve_one(3, 243, 0, 0, lat, ens);
    // ptr back at 0: with 0 and 3 pending, 0 must win.
    set_base(0, 5);
    set_base(3, 6);
    rif.req_valid = 4'b1001;
    #1;
    serve_one(0, 3125, 0, 0, lat, ens);
    serve_one(3, 7776, 0, 0, lat, ens);

    // Requester 2 alone, then 1 and 3 together -> 3 before 1.
    step();
    set_base(2, 2);
    rif.req_valid[2] = 1'b1;
    #1;
    serve_one(2, 32, 0, 0, lat, ens);
    set_base(1, 1);
    set_base(3, 3);
    rif.req_valid[1] = 1'b1;
    rif.req_valid[3] = 1'b1;
    #1;
    serve_one(3, 243, 0, 0, lat, ens);
    serve_one(1, 1, 0, 0, lat, ens);

    // Backpressure on requester 0 (ptr=2, so 0 wins over 1) with others' resp_ready high.
    set_base(0, 3);
    set_base(1, 2);
    rif.req_valid[0] = 1'b1;
    rif.req_valid[1] = 1'b1;
    #1;
    serve_one(0, 243, 0, 10, lat, ens);
    serve_one(1, 32, 0, 0, lat, ens);

    // Unit never finishes: watchdog after exactly TO RUN cycles.
    stub_hang = 1'b1;
    set_base(2, 7);
    rif.req_valid[2] = 1'b1;
    #1;
    serve_one(2, 0, 1, 0, lat, ens);
    chk("t5_run_cycles", ens, TO);
    chk("t5_latency", lat, 2 + TO);
    stub_hang = 1'b0;
    step();
    chk("t5_err_held", rif.resp_err, 1);
    set_base(3, 2);
    rif.req_valid[3] = 1'b1;
    #1;
    serve_one(3, 32, 0, 0, lat, ens);

    // Reset in the middle of RUN aborts the job.
    set_base(0, 2);
    rif.req_valid[0] = 1'b1;
    #1;
    begin
      int n;
      n = 0;
      while (rif.req_ready[0] == 1'b0 && n < 50) begin step(); n++; end
      step();
      rif.req_valid[0] = 1'b0;
      n = 0;
      while (pow_en == 1'b0 && n < 50) begin step(); n++; end
      chk("t6_in_run", pow_en, 1);
      step();
      step();
    end
    rst = 1'b0;
    #1;
    check_reset_vals("t6");
    step();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("t6_no_resp", rif.resp_valid, 0);
    set_base(0, 4);
    rif.req_valid[0] = 1'b1;
    #1;
    serve_one(0, 1024, 0, 0, lat, ens);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
